// File: rtl/iis_pkg.sv
// Shared I2S definitions: slot/word geometry and the stereo sample pair type.
// Used by both the transmitter and the receiver.
package iis_pkg;
    localparam int SLOT_W    = 32;
    localparam int WORD_W    = 24;
    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef struct packed {
        logic signed [WORD_W-1:0] L;
        logic signed [WORD_W-1:0] R;
    } pcm_pair_t;
endpackage

// File: rtl/iis_pcm_tx_if.sv
// Stereo PCM sample-pair handshake between a sample source and the I2S transmitter.
interface iis_pcm_tx_if #(
    parameter int WORD_W = iis_pkg::WORD_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WORD_W-1:0] pcm_L;
    logic signed [WORD_W-1:0] pcm_R;

    modport master (output in_valid, output pcm_L, output pcm_R, input in_ready);
    modport slave  (input in_valid, input pcm_L, input pcm_R, output in_ready);
endinterface

// File: rtl/iis_frame_ctr.sv
// I2S frame position counter: owns cnt, the registered word select and the
// frame-load strobe, all stalled while en_i is low.
module iis_frame_ctr #(
    parameter int SLOT_W = iis_pkg::SLOT_W
) (
    input  logic bclk,
    input  logic rst_n,
    input  logic en_i,
    output logic ws_o,
    output logic load_strobe_o
);
    import iis_pkg::*;

    localparam int FLEN = 2 * SLOT_W;
    localparam int CW   = $clog2(FLEN);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ws_q, ws_d;

    // ws is derived from the next count so it always agrees with cnt.
    always_comb begin
        cnt_d = cnt_q;
        ws_d  = ws_q;
        if (en_i) begin
            cnt_d = (cnt_q == CW'(FLEN - 1)) ? '0 : cnt_q + 1'b1;
            ws_d  = (cnt_d >= CW'(SLOT_W));
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ws_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ws_q  <= ws_d;
        end
    end

    assign ws_o          = ws_q;
    assign load_strobe_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/iis_pcm_tx.sv
// I2S master transmitter: one-pair holding buffer, frame shift register, Philips timing.
// Optional saturating underrun counter enabled by defining IIS_TX_UNDERRUN_CNT_EN.
module iis_pcm_tx #(
    parameter int SLOT_W = iis_pkg::SLOT_W,
    parameter int WORD_W = iis_pkg::WORD_W
) (
    input  logic               bclk,
    input  logic               rst_n,
    input  logic               en,
    iis_pcm_tx_if.slave        pcm_if,
    output logic               ws,
    output logic               sdata,
    output logic               frame_start,
    output logic               underrun
`ifdef IIS_TX_UNDERRUN_CNT_EN
   ,input  logic               underrun_clr,
    output logic [15:0]        underrun_cnt
`endif
);
    import iis_pkg::*;

    localparam int FLEN = 2 * SLOT_W;

    function automatic logic [SLOT_W-1:0] justify(input logic signed [WORD_W-1:0] w);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_W-1 -: WORD_W] = w;
        return s;
    endfunction

    logic signed [WORD_W-1:0] hold_L_q, hold_L_d, hold_R_q, hold_R_d;
    logic                     hold_full_q, hold_full_d;
    logic [FLEN-1:0]          sr_q, sr_d;
    logic                     frame_start_q, frame_start_d;
    logic                     underrun_q, underrun_d;
    logic                     load_strobe;
    logic                     accept;

    iis_frame_ctr #(.SLOT_W(SLOT_W)) u_ctr (
        .bclk          (bclk),
        .rst_n         (rst_n),
        .en_i          (en),
        .ws_o          (ws),
        .load_strobe_o (load_strobe)
    );

    assign accept = pcm_if.in_valid && !hold_full_q;

    // A same-edge accept into an empty hold is not seen by that load; it waits a frame.
    always_comb begin
        hold_L_d      = hold_L_q;
        hold_R_d      = hold_R_q;
        hold_full_d   = hold_full_q;
        sr_d          = sr_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        if (load_strobe) begin
            frame_start_d = 1'b1;
            underrun_d    = !hold_full_q;
            sr_d          = hold_full_q ? {justify(hold_L_q), justify(hold_R_q)} : '0;
            hold_full_d   = 1'b0;
        end else if (en) begin
            sr_d = sr_q << 1;
        end
        if (accept) begin
            hold_L_d    = pcm_if.pcm_L;
            hold_R_d    = pcm_if.pcm_R;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q          <= '0;
            hold_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            hold_full_q   <= hold_full_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // Sample payload carries no reset; hold_full_q alone marks it valid.
    always_ff @(posedge bclk) begin
        hold_L_q <= hold_L_d;
        hold_R_q <= hold_R_d;
    end

`ifdef IIS_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_clr)
            underrun_cnt_d = '0;
        else if (underrun_d && (underrun_cnt_q != 16'hFFFF))
            underrun_cnt_d = underrun_cnt_q + 16'd1;
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) underrun_cnt_q <= '0;
        else        underrun_cnt_q <= underrun_cnt_d;
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign pcm_if.in_ready = !hold_full_q;
    assign sdata           = sr_q[FLEN-1];
    assign frame_start     = frame_start_q;
    assign underrun        = underrun_q;
endmodule

// File: tb/tb_iis_pcm_tx.sv
// Self-checking bench for iis_pcm_tx: frame-position reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_iis_pcm_tx;
    import iis_pkg::*;

    logic bclk  = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic ws, sdata, frame_start, underrun;
    logic underrun_clr = 1'b0;
`ifdef IIS_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 bclk = ~bclk;

    iis_pcm_tx_if #(.WORD_W(WORD_W)) pcm_if ();

    iis_pcm_tx #(.SLOT_W(SLOT_W), .WORD_W(WORD_W)) dut (
        .bclk         (bclk),
        .rst_n        (rst_n),
        .en           (en),
        .pcm_if       (pcm_if.slave),
        .ws           (ws),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
`ifdef IIS_TX_UNDERRUN_CNT_EN
       ,.underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: position in frame, pending pair, and the frame now on the wire.
    int                   m_cnt       = 0;
    bit                   m_hold_full = 1'b0;
    pcm_pair_t            m_hold;
    logic [FRAME_LEN-1:0] m_frame     = '0;
    bit                   m_fs        = 1'b0;
    bit                   m_ur        = 1'b0;
    int                   m_urcnt     = 0;

    function automatic logic [FRAME_LEN-1:0] frame_of(input pcm_pair_t p);
        return {p.L, {(SLOT_W-WORD_W){1'b0}}, p.R, {(SLOT_W-WORD_W){1'b0}}};
    endfunction

    always @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt       = 0;
            m_hold_full = 1'b0;
            m_frame     = '0;
            m_fs        = 1'b0;
            m_ur        = 1'b0;
            m_urcnt     = 0;
        end else begin
            bit load, acc;
            load = en && (m_cnt == 0);
            acc  = pcm_if.in_valid && !m_hold_full;
            m_fs = load;
            m_ur = load && !m_hold_full;
            if (load) begin
                m_frame     = m_hold_full ? frame_of(m_hold) : '0;
                m_hold_full = 1'b0;
            end
            if (acc) begin
                m_hold      = '{L: pcm_if.pcm_L, R: pcm_if.pcm_R};
                m_hold_full = 1'b1;
            end
            if (en) m_cnt = (m_cnt + 1) % FRAME_LEN;
            if (underrun_clr) m_urcnt = 0;
            else if (m_ur && m_urcnt < 65535) m_urcnt++;
        end
    end

    // Bit shown while at position c (1..FRAME_LEN, where 0 means the last bit).
    always @(negedge bclk) begin
        logic exp_sd;
        exp_sd = (m_cnt == 0) ? m_frame[0] : m_frame[FRAME_LEN - m_cnt];
        check("ws",          64'(ws),              64'(m_cnt >= SLOT_W));
        check("sdata",       64'(sdata),           64'(exp_sd));
        check("in_ready",    64'(pcm_if.in_ready), 64'(!m_hold_full));
        check("frame_start", 64'(frame_start),     64'(m_fs));
        check("underrun",    64'(underrun),        64'(m_ur));
`ifdef IIS_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", 64'(underrun_cnt),   64'(m_urcnt));
`endif
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    logic [63:0] cap, wcap;
    int nfs, nur, nws, n;
    logic orv, rdy;

    initial begin
        pcm_if.in_valid = 1'b0;
        pcm_if.pcm_L    = '0;
        pcm_if.pcm_R    = '0;

        repeat (3) tick();
        check("rst ws",          64'(ws),              64'd0);
        check("rst sdata",       64'(sdata),           64'd0);
        check("rst in_ready",    64'(pcm_if.in_ready), 64'd1);
        check("rst frame_start", 64'(frame_start),     64'd0);
        check("rst underrun",    64'(underrun),        64'd0);
        rst_n = 1'b1;
        tick();

        // First pair held before the first frame.
        pcm_if.pcm_L    = 24'hA5F00F;
        pcm_if.pcm_R    = 24'h123456;
        pcm_if.in_valid = 1'b1;
        tick();
        pcm_if.in_valid = 1'b0;
        en  = 1'b1;
        cap = '0; wcap = '0; nfs = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            cap  = {cap[62:0], sdata};
            wcap = {wcap[62:0], ws};
            if (frame_start) nfs++;
        end
        check("frame1 bits", cap,       64'hA5F00F00_12345600);
        check("frame1 ws",   wcap,      64'h00000001_FFFFFFFE);
        check("frame1 fs",   64'(nfs),  64'd1);

        // Three starved frames.
        nur = 0; orv = 1'b0;
        for (int i = 0; i < 192; i++) begin
            tick();
            if (underrun) nur++;
            orv = orv | sdata;
        end
        check("mute underruns", 64'(nur), 64'd3);
        check("mute sdata",     64'(orv), 64'd0);
`ifdef IIS_TX_UNDERRUN_CNT_EN
        check("underrun_cnt 3", 64'(underrun_cnt), 64'd3);
`endif

        // Source always valid: one accept per frame.
        n = 0;
        for (int i = 0; i < 256; i++) begin
            pcm_if.pcm_L    = 24'h0A0000 + WORD_W'(n);
            pcm_if.pcm_R    = 24'hF00000 + WORD_W'(n);
            pcm_if.in_valid = 1'b1;
            rdy = pcm_if.in_ready;
            tick();
            if (rdy) n++;
        end
        pcm_if.in_valid = 1'b0;
        check("accepts per 4 frames", 64'(n), 64'd4);

        // en toggling every cycle: half-rate, same bitstream.
        cap = '0; nws = 0;
        for (int k = 0; k < 128; k++) begin
            en = (k % 2 == 0);
            tick();
            if (en) cap = {cap[62:0], sdata};
            if (ws) nws++;
        end
        en = 1'b1;
        check("stall bits",  cap,      64'h0A000300_F0000300);
        check("stall ws hi", 64'(nws), 64'd64);

        // Reset mid-left-slot with data on the wire and the hold full.
        en = 1'b0;
        pcm_if.pcm_L    = 24'hFFFFFF;
        pcm_if.pcm_R    = 24'h000001;
        pcm_if.in_valid = 1'b1;
        tick();
        pcm_if.in_valid = 1'b0;
        en = 1'b1;
        tick();
        pcm_if.pcm_L    = 24'h555555;
        pcm_if.pcm_R    = 24'hAAAAAA;
        pcm_if.in_valid = 1'b1;
        tick();
        pcm_if.in_valid = 1'b0;
        repeat (18) tick();
        check("pre-rst sdata",    64'(sdata),           64'd1);
        check("pre-rst in_ready", 64'(pcm_if.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("async rst ws",       64'(ws),              64'd0);
        check("async rst sdata",    64'(sdata),           64'd0);
        check("async rst in_ready", 64'(pcm_if.in_ready), 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        nur = 0; orv = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (underrun) nur++;
            orv = orv | sdata;
        end
        check("post-rst underrun", 64'(nur), 64'd1);
        check("post-rst sdata",    64'(orv), 64'd0);
`ifdef IIS_TX_UNDERRUN_CNT_EN
        check("underrun_cnt post-rst", 64'(underrun_cnt), 64'd1);
`endif
        pcm_if.pcm_L    = 24'h800000;
        pcm_if.pcm_R    = 24'h7FFFFF;
        pcm_if.in_valid = 1'b1;
        tick();
        pcm_if.in_valid = 1'b0;
        repeat (130) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
